// File: rtl/user_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : user_wb_pkg
// Description : Shared constants for the user-area Wishbone register block:
//               register byte offsets inside the 256-byte window, CTRL bit
//               indices, the default identification word and a byte-lane
//               merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package user_wb_pkg;

    // Byte offsets within the slave window (address bits [7:0], word aligned)
    localparam logic [7:0] OFF_ID       = 8'h00;
    localparam logic [7:0] OFF_CTRL     = 8'h04;
    localparam logic [7:0] OFF_GPIO_OUT = 8'h08;
    localparam logic [7:0] OFF_GPIO_OEB = 8'h0C;
    localparam logic [7:0] OFF_COUNTER  = 8'h10;
    localparam logic [7:0] OFF_SCRATCH  = 8'h40;

    // CTRL register bits
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hAB60_0001;

    // Replace only the bytes whose lane select is set.
    function automatic logic [31:0] wb_merge(input logic [31:0] i_old,
                                             input logic [31:0] i_new,
                                             input logic [3:0]  i_sel);
        logic [31:0] w_res;
        for (int b = 0; b < 4; b++) begin
            w_res[8*b +: 8] = i_sel[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : user_wb_if
// Description : Wishbone-classic slave bus bundle (cyc/stb/we/sel/adr/dat,
//               ack and read data). master modport drives requests, slave
//               modport answers them.
//               USER_WB_ERR_EN : adds the wbs_err_o error response line.
// Revision    : 1.0 - initial release
// ============================================================================
interface user_wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
`ifdef USER_WB_ERR_EN
    logic        wbs_err_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o, wbs_err_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o, wbs_err_o
    );
`else
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
`endif
endinterface
`default_nettype wire

// File: rtl/user_wb_scratch_ram.sv
`default_nettype none
// ============================================================================
// Module      : user_wb_scratch_ram
// Description : SCRATCH_WORDS x 32 storage, byte-writable, synchronous write,
//               combinational read. Contents are not reset.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_sel    - byte lane enables for the write
//               i_addr   - word index
//               i_wdata  - write data
//               o_rdata  - read data for i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module user_wb_scratch_ram #(
    parameter int SCRATCH_WORDS = 8,
    parameter int AW            = 3
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [3:0]    i_sel,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] r_mem [SCRATCH_WORDS];

    for (genvar b = 0; b < 4; b++) begin : g_lane
        always_ff @(posedge clk) begin
            if (i_we && i_sel[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/user_wb_port_regs.sv
`default_nettype none
// ============================================================================
// Module      : user_wb_port_regs
// Description : Wishbone-classic register slave for the user project area.
//               ID, CTRL, GPIO_OUT/GPIO_OEB (drive pads [31:16]), a 32-bit
//               free-running counter and a scratch RAM.
// Ports       : wb_clk_i  - bus clock (only clock)
//               wb_rst_n  - asynchronous active-low reset
//               wb        - Wishbone slave bundle (user_wb_if.slave)
//               io_out    - pad output values
//               io_oeb    - pad output enables, active low
// Options     : USER_WB_ERR_EN - unmapped in-window offsets answer with
//               wbs_err_o instead of wbs_ack_o.
// Revision    : 1.0 - initial release
// ============================================================================
module user_wb_port_regs
    import user_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          SCRATCH_WORDS = 8,
    parameter logic [31:0] ID_VALUE      = ID_VALUE_DEFAULT
) (
    input  wire logic  wb_clk_i,
    input  wire logic  wb_rst_n,
    user_wb_if.slave   wb,
    output logic [15:0] io_out,
    output logic [15:0] io_oeb
);

    localparam int         c_AW      = (SCRATCH_WORDS > 1) ? $clog2(SCRATCH_WORDS) : 1;
    localparam logic [8:0] c_SCR_END = 9'(OFF_SCRATCH) + 9'(4 * SCRATCH_WORDS);

    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_ctrl_en;
    logic [15:0] r_gpio_out;
    logic [15:0] r_gpio_oeb;
    logic [31:0] r_counter;

    logic        w_hit;
    logic        w_busy;
    logic        w_sel;
    logic        w_wr;
    logic        w_ack_ok;
    logic [7:0]  w_off;
    logic        w_is_scratch;
    logic        w_mapped;
    logic [31:0] w_rdata;
    logic [31:0] w_scr_rdata;
    logic [31:0] w_merged;

    assign w_hit = (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // The busy term keeps a held strobe from being selected on the ack cycle,
    // so a continuous strobe is answered every second cycle.
    assign w_sel = wb.wbs_cyc_i & wb.wbs_stb_i & w_hit & ~w_busy;
    assign w_wr  = w_sel & wb.wbs_we_i;
    assign w_off = {wb.wbs_adr_i[7:2], 2'b00};

    assign w_is_scratch = ({1'b0, w_off} >= 9'(OFF_SCRATCH)) && ({1'b0, w_off} < c_SCR_END);

    always_comb begin
        w_rdata  = 32'h0;
        w_mapped = 1'b1;
        case (w_off)
            OFF_ID:       w_rdata = ID_VALUE;
            OFF_CTRL:     w_rdata = {31'h0, r_ctrl_en};
            OFF_GPIO_OUT: w_rdata = {16'h0, r_gpio_out};
            OFF_GPIO_OEB: w_rdata = {16'h0, r_gpio_oeb};
            OFF_COUNTER:  w_rdata = r_counter;
            default: begin
                if (w_is_scratch) begin
                    w_rdata = w_scr_rdata;
                end else begin
                    w_mapped = 1'b0;
                end
            end
        endcase
    end

`ifdef USER_WB_ERR_EN
    logic r_err;

    assign w_busy        = r_ack | r_err;
    assign w_ack_ok      = w_mapped;
    assign wb.wbs_err_o  = r_err;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_sel & ~w_mapped;
        end
    end

    logic w_unused;
    assign w_unused = ^{wb.wbs_adr_i[1:0]};
`else
    assign w_busy   = r_ack;
    assign w_ack_ok = 1'b1;

    logic w_unused;
    assign w_unused = ^{wb.wbs_adr_i[1:0], w_mapped};
`endif

    assign w_merged = wb_merge(w_rdata, wb.wbs_dat_i, wb.wbs_sel_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack      <= 1'b0;
            r_dat      <= 32'h0;
            r_ctrl_en  <= 1'b0;
            r_gpio_out <= 16'h0;
            r_gpio_oeb <= 16'hFFFF;
            r_counter  <= 32'h0;
        end else begin
            r_ack <= w_sel & w_ack_ok;
            r_dat <= (w_sel && w_ack_ok && !wb.wbs_we_i) ? w_rdata : 32'h0;

            if (r_ctrl_en) begin
                r_counter <= r_counter + 32'd1;
            end

            if (w_wr) begin
                case (w_off)
                    OFF_CTRL: begin
                        if (wb.wbs_sel_i[0]) begin
                            r_ctrl_en <= wb.wbs_dat_i[CTRL_EN];
                            // Clear is a pulse: it zeroes the counter on the
                            // write edge (overriding the increment) and is
                            // never stored, so it reads back as 0.
                            if (wb.wbs_dat_i[CTRL_CLR]) begin
                                r_counter <= 32'h0;
                            end
                        end
                    end
                    OFF_GPIO_OUT: r_gpio_out <= w_merged[15:0];
                    OFF_GPIO_OEB: r_gpio_oeb <= w_merged[15:0];
                    default: ;
                endcase
            end
        end
    end

    user_wb_scratch_ram #(
        .SCRATCH_WORDS (SCRATCH_WORDS),
        .AW            (c_AW)
    ) u_scratch (
        .clk     (wb_clk_i),
        .i_we    (w_wr & w_is_scratch),
        .i_sel   (wb.wbs_sel_i),
        .i_addr  (wb.wbs_adr_i[c_AW+1:2]),
        .i_wdata (wb.wbs_dat_i),
        .o_rdata (w_scr_rdata)
    );

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign io_out       = r_gpio_out;
    assign io_oeb       = r_gpio_oeb;

endmodule
`default_nettype wire

// File: tb/tb_user_wb_port_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_wb_port_regs
// Description : Self-checking bench for user_wb_port_regs: directed bring-up
//               sequence plus randomized register/scratch traffic compared
//               against a register-map model.
//               USER_WB_ERR_EN : expects error responses on unmapped offsets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_wb_port_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ID   = 32'hAB60_0001;
    localparam int          NSCR = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] io_out;
    logic [15:0] io_oeb;

    user_wb_if bus ();

    user_wb_port_regs dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .wb       (bus),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model of the architectural state
    logic [15:0] m_gout;
    logic [15:0] m_goeb;
    logic [31:0] m_scr [NSCR];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    function automatic logic get_err();
`ifdef USER_WB_ERR_EN
        return bus.wbs_err_o;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic is_mapped(input logic [7:0] off);
        return (off <= 8'h10) || (off >= 8'h40 && off < 8'h40 + 8'(4 * NSCR));
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] off);
        if (off == 8'h00) return ID;
        if (off == 8'h08) return {16'h0, m_gout};
        if (off == 8'h0C) return {16'h0, m_goeb};
        if (off >= 8'h40 && off < 8'h40 + 8'(4 * NSCR)) return m_scr[(off - 8'h40) / 4];
        return 32'h0;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] v = old;
        for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = d[8*b +: 8];
        return v;
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] t;
        if (off == 8'h08) begin
            t = lanes({16'h0, m_gout}, d, sel);
            m_gout = t[15:0];
        end else if (off == 8'h0C) begin
            t = lanes({16'h0, m_goeb}, d, sel);
            m_goeb = t[15:0];
        end else if (off >= 8'h40 && off < 8'h40 + 8'(4 * NSCR)) begin
            m_scr[(off - 8'h40) / 4] = lanes(m_scr[(off - 8'h40) / 4], d, sel);
        end
    endtask

    // One bus transfer; caller is off the clock edge. Returns the response
    // flags, captured read data and latency in cycles (0 = no response).
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] sel, input int budget,
                           output logic [31:0] rd, output logic ack, output logic err,
                           output int lat);
        rd  = 32'h0;
        ack = 1'b0;
        err = 1'b0;
        lat = 0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = d;
        bus.wbs_sel_i = sel;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o || get_err()) begin
                ack = bus.wbs_ack_o;
                err = get_err();
                rd  = bus.wbs_dat_o;
                lat = i + 1;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] rd;
        logic        a, e;
        int          l;
        wb_xfer(1'b1, BASE | 32'(off), d, sel, 8, rd, a, e, l);
        check_eq($sformatf("wr_ack_%02h", off), {31'h0, a}, 32'h1);
        model_write(off, d, sel);
    endtask

    task automatic rd_word(input logic [7:0] off, output logic [31:0] v);
        logic a, e;
        int   l;
        wb_xfer(1'b0, BASE | 32'(off), 32'h0, 4'hF, 8, v, a, e, l);
        check_eq($sformatf("rd_ack_%02h", off), {31'h0, a}, 32'h1);
    endtask

    logic [31:0] v, c0, c1;
    logic        a, e;
    int          lat, nack;
    logic [7:0]  unm [7] = '{8'h14, 8'h18, 8'h20, 8'h3C, 8'h60, 8'h80, 8'hFC};

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        m_gout = 16'h0;
        m_goeb = 16'hFFFF;
        for (int i = 0; i < NSCR; i++) m_scr[i] = 32'hx;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check_eq("rst_dat", bus.wbs_dat_o, 32'h0);
        check_eq("rst_io_out", {16'h0, io_out}, 32'h0);
        check_eq("rst_io_oeb", {16'h0, io_oeb}, 32'h0000_FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ID read with one-cycle latency, single-cycle ack
        wb_xfer(1'b0, BASE, 32'h0, 4'hF, 8, v, a, e, lat);
        check_eq("id_data", v, ID);
        check_eq("id_latency", 32'(lat), 32'd1);
        @(posedge clk);
        #1;
        check_eq("ack_pulse", {31'h0, bus.wbs_ack_o}, 32'h0);
        check_eq("dat_idle", bus.wbs_dat_o, 32'h0);

        // Held strobe for four cycles -> two acks
        nack = 0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_adr_i = BASE;
        bus.wbs_sel_i = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) nack++;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("held_stb_acks", 32'(nack), 32'd2);

        // Pad bring-up sequence
        wr(8'h0C, 32'h0000_0000, 4'hF);
        check_eq("oeb_cleared", {16'h0, io_oeb}, 32'h0);
        wr(8'h08, 32'h0000_AB60, 4'hF);
        check_eq("pads_ab60", {16'h0, io_out}, 32'h0000_AB60);
        wr(8'h08, 32'h0000_AB61, 4'hF);
        check_eq("pads_ab61", {16'h0, io_out}, 32'h0000_AB61);

        // Scratch byte lanes
        wr(8'h40, 32'hDEAD_BEEF, 4'hF);
        wr(8'h5C, 32'h1357_9BDF, 4'hF);
        wr(8'h40, 32'h0000_1100, 4'b0010);
        rd_word(8'h40, v);
        check_eq("scr_lane", v, 32'hDEAD_11EF);
        rd_word(8'h5C, v);
        check_eq("scr_indep", v, 32'h1357_9BDF);
        wr(8'h5C, 32'hFFFF_FFFF, 4'h0);
        rd_word(8'h5C, v);
        check_eq("sel_none", v, 32'h1357_9BDF);
        for (int i = 1; i < NSCR - 1; i++) wr(8'h40 + 8'(4 * i), $urandom, 4'hF);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            logic [7:0]  off;
            logic        we;
            logic [31:0] d;
            logic [3:0]  sel;
            case ($urandom_range(0, 4))
                0: off = 8'h00;
                1: off = 8'h08;
                2: off = 8'h0C;
                3: off = 8'h40 + 8'(4 * $urandom_range(0, NSCR - 1));
                default: off = unm[$urandom_range(0, 6)];
            endcase
            we  = 1'($urandom_range(0, 1));
            d   = $urandom;
            sel = 4'($urandom);
            wb_xfer(we, BASE | 32'(off), d, sel, 8, v, a, e, lat);
`ifdef USER_WB_ERR_EN
            check_eq($sformatf("rnd%0d_ack", n), {30'h0, a, e}, is_mapped(off) ? 32'h2 : 32'h1);
`else
            check_eq($sformatf("rnd%0d_ack", n), {30'h0, a, e}, 32'h2);
`endif
            if (we) model_write(off, d, sel);
            else    check_eq($sformatf("rnd%0d_rd_%02h", n, off), v, model_read(off));
            check_eq($sformatf("rnd%0d_pads", n), {io_oeb, io_out}, {m_goeb, m_gout});
        end

        // Counter: rate, clear, clear-over-enable, wrap
        wr(8'h04, 32'h1, 4'hF);
        rd_word(8'h10, c0);
        repeat (100) @(posedge clk);
        #1;
        rd_word(8'h10, c1);
        check_eq("cnt_rate", {31'h0, (c1 - c0 >= 98) && (c1 - c0 <= 102)}, 32'h1);
        wr(8'h04, 32'h2, 4'hF);
        rd_word(8'h10, v);
        check_eq("cnt_clear", {31'h0, v < 5}, 32'h1);
        rd_word(8'h04, v);
        check_eq("ctrl_off", v, 32'h0);
        wr(8'h04, 32'h1, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        wr(8'h04, 32'h3, 4'hF);
        rd_word(8'h10, v);
        check_eq("clr_wins", {31'h0, v < 5}, 32'h1);
        rd_word(8'h04, v);
        check_eq("ctrl_selfclr", v, 32'h1);
        wr(8'h10, 32'h0, 4'hF);
        wr(8'h04, 32'h0, 4'hF);
        force dut.r_counter = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.r_counter;
        rd_word(8'h10, v);
        check_eq("cnt_max", v, 32'hFFFF_FFFF);
        wr(8'h04, 32'h1, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        rd_word(8'h10, v);
        check_eq("cnt_wrap", {31'h0, v < 8}, 32'h1);
        wr(8'h04, 32'h0, 4'hF);

        // Unmapped in-window offset and out-of-window address
        wb_xfer(1'b0, BASE | 32'h20, 32'h0, 4'hF, 8, v, a, e, lat);
`ifdef USER_WB_ERR_EN
        check_eq("unmapped_resp", {30'h0, a, e}, 32'h1);
`else
        check_eq("unmapped_resp", {30'h0, a, e}, 32'h2);
`endif
        check_eq("unmapped_data", v, 32'h0);
        wb_xfer(1'b1, 32'h3000_1000, 32'h0000_5555, 4'hF, 10, v, a, e, lat);
        check_eq("outside_noresp", {30'h0, a, e}, 32'h0);
        check_eq("outside_nowrite", {16'h0, io_out}, {16'h0, m_gout});

        // Reset during a pending GPIO_OUT write
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = BASE | 32'h08;
        bus.wbs_dat_i = 32'h0000_1234;
        bus.wbs_sel_i = 4'hF;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_mid_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_gout = 16'h0;
        m_goeb = 16'hFFFF;
        @(posedge clk);
        #1;
        check_eq("rst_mid_gpio", {io_oeb, io_out}, 32'hFFFF_0000);
        rd_word(8'h08, v);
        check_eq("rst_mid_rd", v, 32'h0);
        rd_word(8'h40, v);
        check_eq("scr_survives", v, m_scr[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
